// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - multi-channel push-button conditioner
// Sync, N-sample debounce on a shared tick, press/release/long/repeat pulses.
module key_debounce_array #(
    parameter int NUM_KEYS         = 4,
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int SAMPLE_PERIOD_US = 1000,
    parameter int STABLE_CNT       = 20,
    parameter int ACTIVE_LOW       = 1,
    parameter int LONG_CNT         = 1000,
    parameter int REPEAT_CNT       = 200
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    output logic [NUM_KEYS-1:0] press_o,
    output logic [NUM_KEYS-1:0] release_o,
    output logic [NUM_KEYS-1:0] long_o,
    output logic [NUM_KEYS-1:0] repeat_o
);
    localparam int DIV      = CLK_FREQ_HZ / 1_000_000 * SAMPLE_PERIOD_US;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STAB_W   = $clog2(STABLE_CNT + 1);
    localparam int HOLD_MAX = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;
    localparam int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [STAB_W-1:0] STAB_HIT   = STAB_W'(STABLE_CNT);
    localparam logic [HOLD_W-1:0] LONG_HIT   = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] REPEAT_HIT = HOLD_W'(REPEAT_CNT);
    localparam logic              POL        = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_q;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Synchroniser flops come out of reset at the raw "released" level.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= {NUM_KEYS{POL}};
            sync_q    <= {NUM_KEYS{POL}};
        end else begin
            sync_meta <= key_i;
            sync_q    <= sync_meta;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        state_t            state, state_nxt;
        logic              level, level_nxt;
        logic [STAB_W-1:0] stab_cnt, stab_nxt, stab_inc;
        logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
        logic              pressed_s;
        logic              press_q, release_q, long_q, repeat_q;
        logic              press_nxt, release_nxt, long_nxt, repeat_nxt;

        assign pressed_s = sync_q[k] ^ POL;
        assign stab_inc  = stab_cnt + 1'b1;
        assign hold_inc  = hold_cnt + 1'b1;

        always_comb begin
            state_nxt   = state;
            level_nxt   = level;
            stab_nxt    = stab_cnt;
            hold_nxt    = hold_cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
            repeat_nxt  = 1'b0;
            if (tick) begin
                if (pressed_s != level) begin
                    if (stab_inc == STAB_HIT) begin
                        level_nxt = ~level;
                        stab_nxt  = '0;
                    end else begin
                        stab_nxt = stab_inc;
                    end
                end else begin
                    stab_nxt = '0;
                end

                // The FSM reacts to the level accepted on this very tick.
                case (state)
                    ST_RELEASED: begin
                        if (level_nxt && !level) begin
                            state_nxt = ST_HELD;
                            press_nxt = 1'b1;
                            hold_nxt  = '0;
                        end
                    end
                    ST_HELD: begin
                        if (!level_nxt) begin
                            state_nxt   = ST_RELEASED;
                            release_nxt = 1'b1;
                            hold_nxt    = '0;
                        end else if (LONG_CNT != 0) begin
                            if (hold_inc == LONG_HIT) begin
                                state_nxt = ST_REPEATING;
                                long_nxt  = 1'b1;
                                hold_nxt  = '0;
                            end else begin
                                hold_nxt = hold_inc;
                            end
                        end
                    end
                    ST_REPEATING: begin
                        if (!level_nxt) begin
                            state_nxt   = ST_RELEASED;
                            release_nxt = 1'b1;
                            hold_nxt    = '0;
                        end else if (REPEAT_CNT != 0) begin
                            if (hold_inc == REPEAT_HIT) begin
                                repeat_nxt = 1'b1;
                                hold_nxt   = '0;
                            end else begin
                                hold_nxt = hold_inc;
                            end
                        end
                    end
                    default: begin
                        state_nxt = ST_RELEASED;
                        hold_nxt  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n) begin
                state     <= ST_RELEASED;
                level     <= 1'b0;
                stab_cnt  <= '0;
                hold_cnt  <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_nxt;
                level     <= level_nxt;
                stab_cnt  <= stab_nxt;
                hold_cnt  <= hold_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                repeat_q  <= repeat_nxt;
            end
        end

        assign key_level_o[k] = level;
        assign press_o[k]     = press_q;
        assign release_o[k]   = release_q;
        assign long_o[k]      = long_q;
        assign repeat_o[k]    = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - directed bench with a sample-window reference model
module tb_key_debounce_array;
    localparam int NK     = 2;
    localparam int DIV    = 4;
    localparam int STABLE = 3;
    localparam int LONG   = 10;
    localparam int REP    = 5;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_i;
    logic [NK-1:0] key_level_o, press_o, release_o, long_o, repeat_o;

    key_debounce_array #(
        .NUM_KEYS(NK), .CLK_FREQ_HZ(1_000_000), .SAMPLE_PERIOD_US(4),
        .STABLE_CNT(STABLE), .ACTIVE_LOW(1), .LONG_CNT(LONG), .REPEAT_CNT(REP)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .key_i(key_i),
        .key_level_o(key_level_o), .press_o(press_o), .release_o(release_o),
        .long_o(long_o), .repeat_o(repeat_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips when the last STABLE tick samples all
    // disagree with it; events derive from tick distance to the press tick.
    logic [NK-1:0]     m_d1, m_d2;
    logic [NK-1:0]     e_level, e_press, e_release, e_long, e_repeat;
    int                n, tcount, m_e;
    bit                last_tick, m_old, m_all;
    bit [STABLE-1:0]   hist [NK];
    bit                held [NK];
    int                t0 [NK];

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '1; m_d2 = '1; n = 0; tcount = 0; last_tick = 1'b0;
            e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
            for (int k = 0; k < NK; k++) begin
                hist[k] = '0; held[k] = 1'b0; t0[k] = 0;
            end
        end else begin
            e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
            last_tick = (n % DIV == DIV - 1);
            if (last_tick) begin
                tcount++;
                for (int k = 0; k < NK; k++) begin
                    m_old   = e_level[k];
                    hist[k] = {hist[k][STABLE-2:0], ~m_d2[k]};
                    m_all   = 1'b1;
                    for (int j = 0; j < STABLE; j++)
                        if (hist[k][j] == m_old) m_all = 1'b0;
                    if (m_all) e_level[k] = ~m_old;
                    if (e_level[k] && !m_old) begin
                        e_press[k] = 1'b1; held[k] = 1'b1; t0[k] = tcount;
                    end else if (!e_level[k] && m_old) begin
                        e_release[k] = 1'b1; held[k] = 1'b0;
                    end else if (held[k]) begin
                        m_e = tcount - t0[k];
                        if (m_e == LONG) e_long[k] = 1'b1;
                        else if (m_e > LONG && (m_e - LONG) % REP == 0) e_repeat[k] = 1'b1;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = key_i;
            n++;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check("level",   int'(key_level_o), int'(e_level));
            check("press",   int'(press_o),     int'(e_press));
            check("release", int'(release_o),   int'(e_release));
            check("long",    int'(long_o),      int'(e_long));
            check("repeat",  int'(repeat_o),    int'(e_repeat));
        end
    end

    int cnt_press [NK], cnt_release [NK], cnt_long [NK], cnt_rep [NK];
    int n_press0, n_long0, n_rep0;

    always @(negedge clk_i) begin
        for (int k = 0; k < NK; k++) begin
            if (press_o[k])   cnt_press[k]++;
            if (release_o[k]) cnt_release[k]++;
            if (long_o[k])    cnt_long[k]++;
            if (repeat_o[k])  cnt_rep[k]++;
        end
        if (press_o[0]) n_press0 = n;
        if (long_o[0])  n_long0  = n;
        if (repeat_o[0]) n_rep0  = n;
    end

    task automatic wait_ticks(input int cnt);
        bit got;
        for (int t = 0; t < cnt; t++) begin
            got = 1'b0;
            for (int i = 0; i < 2 * DIV && !got; i++) begin
                @(posedge clk_i);
                #1;
                got = last_tick;
            end
            if (!got) check("tick_timeout", 0, 1);
        end
    endtask

    task automatic wait_press(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_i);
            if (press_o != '0) found = 1'b1;
        end
        check(name, int'(found), 1);
    endtask

    int s_p0, s_p1, s_r0, s_r1, s_l0, s_q0;

    task automatic snap();
        s_p0 = cnt_press[0]; s_p1 = cnt_press[1];
        s_r0 = cnt_release[0]; s_r1 = cnt_release[1];
        s_l0 = cnt_long[0]; s_q0 = cnt_rep[0];
    endtask

    initial begin
        rst_n = 1'b1;
        key_i = 2'b00;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("in_reset_level", int'(key_level_o), 0);
        check("in_reset_press", int'(press_o), 0);
        rst_n = 1'b1;

        // Keys held through reset: fresh press after 3 ticks, edge 11.
        wait_press("rst_press_seen");
        check("rst_press_val", int'(press_o), 3);
        check("rst_press_edge", n, 12);
        check("rst_level", int'(key_level_o), 3);
        @(negedge clk_i);
        check("rst_press_width", int'(press_o), 0);
        key_i = 2'b11;
        wait_ticks(6);

        // Bounce p,r,p,r,p then steady: press on 3rd consecutive low tick.
        snap();
        wait_ticks(1); key_i[0] = 1'b0;
        wait_ticks(1); key_i[0] = 1'b1;
        wait_ticks(1); key_i[0] = 1'b0;
        wait_ticks(1); key_i[0] = 1'b1;
        wait_ticks(1); key_i[0] = 1'b0;
        wait_ticks(34);
        check("bounce_press0", cnt_press[0] - s_p0, 1);
        check("bounce_press1", cnt_press[1] - s_p1, 0);
        check("long_count", cnt_long[0] - s_l0, 1);
        check("long_dist", n_long0 - n_press0, LONG * DIV);
        check("repeat_count", cnt_rep[0] - s_q0, 4);
        check("last_repeat_dist", n_rep0 - n_press0, 30 * DIV);
        key_i[0] = 1'b1;
        wait_ticks(6);

        // Release accepted on hold tick 10 wins over long.
        snap();
        wait_ticks(1); key_i[0] = 1'b0;
        wait_ticks(10); key_i[0] = 1'b1;
        wait_ticks(6);
        @(negedge clk_i);
        check("prio_press", cnt_press[0] - s_p0, 1);
        check("prio_release", cnt_release[0] - s_r0, 1);
        check("prio_long", cnt_long[0] - s_l0, 0);
        check("prio_repeat", cnt_rep[0] - s_q0, 0);
        check("prio_level", int'(key_level_o), 0);

        // Two keys one cycle apart inside one tick window.
        snap();
        wait_ticks(1); key_i[0] = 1'b0;
        @(posedge clk_i); #1; key_i[1] = 1'b0;
        wait_press("simul_press_seen");
        check("simul_press_val", int'(press_o), 3);
        key_i[1] = 1'b1;
        wait_ticks(6);
        @(negedge clk_i);
        check("indep_release1", cnt_release[1] - s_r1, 1);
        check("indep_release0", cnt_release[0] - s_r0, 0);
        check("indep_level", int'(key_level_o), 1);

        // Reset while key 0 is repeating; it stays held across reset.
        wait_ticks(8);
        snap();
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_level", int'(key_level_o), 0);
        check("mid_reset_release", int'(release_o), 0);
        check("mid_reset_repeat", int'(repeat_o), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        wait_press("rearm_press_seen");
        check("rearm_press_val", int'(press_o), 1);
        check("rearm_press_edge", n, 12);
        check("rearm_no_release", cnt_release[0] - s_r0, 0);

        repeat (8) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
